maclaurin_seq_ctrl: RTL and testbench
=====================================

# maclaurin_seq_ctrl

Sequencer for the `maclauren` series datapath. It holds a batch of signed 8-bit samples in a local buffer and runs one job per batch. For each job it pulses the datapath `start`, drives the series order `N`, and feeds samples whenever the datapath is `ready`. It collects `Y`/`overflow` results, watches `error`, then flushes the datapath with a one-cycle reset. It sits between the host/test logic and `maclauren`, replacing hand-sequenced stimulus.

## Interface
Parameters:
- OUTPUT_WIDTH, 32, width of datapath `Y` and `res_y`
- DEPTH, 32, sample buffer entries; job length limit
- DRAIN_MAX, 16, maximum post-feed cycles to wait for outstanding results

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ld_we  in  1  sample buffer write; ignored while `busy`
- ld_addr  in  $clog2(DEPTH)  write address
- ld_data  in  8  signed sample
- job_start  in  1  start job; honoured only in IDLE
- job_n  in  3  series order, captured at `job_start`
- job_len  in  $clog2(DEPTH)+1  samples to feed, 0..DEPTH
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- done_err  out  1  qualifies `done`: job aborted by `dp_error` or drain timeout
- ov_count  out  $clog2(DEPTH)+1  results with overflow in the current/last job
- res_valid  out  1  result strobe (no backpressure)
- res_y  out  OUTPUT_WIDTH  result value
- res_ov  out  1  result overflow flag
- dp_rst  out  1  datapath reset
- dp_start  out  1  datapath start
- dp_n  out  3  datapath order
- dp_x  out  8  datapath sample
- dp_ready  in  1  datapath accepts `dp_x` this cycle
- dp_valid  in  1  datapath result valid
- dp_y  in  OUTPUT_WIDTH  datapath result
- dp_overflow  in  1  datapath overflow
- dp_error  in  1  datapath error

## Operation
- States:
  - IDLE → START (`job_start`, `job_len`≠0)
  - START → CONFIG
  - CONFIG → FEED
  - FEED → DRAIN (issued == len)
  - DRAIN → FLUSH (received == len, or drain counter == DRAIN_MAX)
  - FLUSH → GAP
  - GAP → IDLE, pulsing `done`
- `job_start` with `job_len`=0: no datapath activity; `done`=1, `done_err`=0 the next cycle; stays IDLE.
- On `job_start`: capture `job_n` into `dp_n` (held until next job); clear issue index, receive count, `ov_count`, drain counter.
- START: `dp_start`=1 for exactly one cycle.
- FEED:
  - `dp_x` = buffer[idx], combinational read.
  - idx increments on each cycle with `dp_ready`=1.
  - Feeding never starves.
- Results are counted in any non-IDLE state on `dp_valid`=1:
  - `res_valid`=`dp_valid`; `res_y`, `res_ov` mirror `dp_y`, `dp_overflow` combinationally.
  - `ov_count` increments when `dp_overflow`=1 on a valid cycle.
  - Receive count saturates at len; extra results are forwarded but not counted.
- DRAIN: drain counter increments each cycle; reaching DRAIN_MAX sets the sticky abort flag.
- `dp_error`=1 in START, CONFIG, FEED or DRAIN → jump to FLUSH and set the abort flag.
- FLUSH: `dp_rst`=1 for one cycle. `dp_rst` = `rst` OR (state == FLUSH).
- GAP: one idle cycle; `done`=1, `done_err`=abort flag; abort flag clears on entry to IDLE.
- Arithmetic:
  - Counters are unsigned.
  - `ov_count` cannot exceed len, so no wrap.
  - idx never exceeds len−1 while reading.

## Timing
- Reset values: state IDLE; `busy`, `done`, `done_err`, `dp_start` = 0; `ov_count`=0; `dp_n`=0; `dp_rst`=1 while `rst`=1.
- `job_start` at edge t → `dp_start` high in cycle t+1, FEED from t+3.
- With `dp_ready` held 1, the last sample is presented at cycle t+2+len.
- Minimum job, fault-free with immediate results: `done` = last result cycle + 3 (DRAIN exit, FLUSH, GAP).
- `rst` mid-job: next cycle IDLE; no `done` pulse; buffer contents preserved (buffer not reset).
- `job_start` while `busy`: ignored. `ld_we` while `busy`: ignored.
- `dp_error` on the same cycle as the final `dp_ready` in FEED: error wins → FLUSH.

## Structure
- `maclaurin_pkg`:
  - state enum (IDLE, START, CONFIG, FEED, DRAIN, FLUSH, GAP)
  - X_WIDTH=8, N_WIDTH=3
- Sub-module `maclaurin_sample_buf`: DEPTH×8 register file, synchronous write, combinational read. The FSM and counters live in the top module.

## Test plan
- Load 20 samples, job_n=2, len=20, `dp_ready` always 1 → `dp_start` one pulse at t+1, `dp_x` sequence = buffer[0..19], 20 `res_valid`, `done`=1 with `done_err`=0, one `dp_rst` pulse.
- `dp_ready` toggling 1010… with len=5 → each sample presented until consumed; idx advances only on ready cycles; 5 samples issued.
- Model asserts `dp_overflow` on results 3 and 7 of len=10 → `ov_count`=2 at `done`.
- `dp_error` raised mid-FEED (idx=4) → FLUSH next cycle, `done_err`=1, no further `dp_x` advance.
- Model withholds last result, DRAIN_MAX=16 → `done_err`=1 after 16 drain cycles; len=0 job → `done` next cycle, no `dp_start`.
- `rst` during DRAIN, then a new job → clean IDLE; the new job runs normally and the buffer still holds the old samples.

Source files
------------

// File: rtl/maclaurin_pkg.sv
// Shared types and widths for the maclauren series sequencer.
package maclaurin_pkg;

  localparam int X_WIDTH = 8;
  localparam int N_WIDTH = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    CONFIG = 3'd2,
    FEED   = 3'd3,
    DRAIN  = 3'd4,
    FLUSH  = 3'd5,
    GAP    = 3'd6
  } seq_state_t;

endpackage

// File: rtl/maclaurin_sample_buf.sv
// Sample register file: synchronous write, combinational read, no reset so
// contents survive a sequencer reset.
module maclaurin_sample_buf
  import maclaurin_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [X_WIDTH-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [X_WIDTH-1:0] rdata
);

  logic [X_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maclaurin_seq_ctrl.sv
// Job sequencer for the maclauren datapath: start pulse, sample feed, result
// collection with overflow counting, drain timeout and a one-cycle flush.
module maclaurin_seq_ctrl
  import maclaurin_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 32,
  parameter int DEPTH        = 32,
  parameter int DRAIN_MAX    = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1,
  localparam int DW = $clog2(DRAIN_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_we,
  input  logic [AW-1:0]           ld_addr,
  input  logic [X_WIDTH-1:0]      ld_data,
  input  logic                    job_start,
  input  logic [N_WIDTH-1:0]      job_n,
  input  logic [LW-1:0]           job_len,
  output logic                    busy,
  output logic                    done,
  output logic                    done_err,
  output logic [LW-1:0]           ov_count,
  output logic                    res_valid,
  output logic [OUTPUT_WIDTH-1:0] res_y,
  output logic                    res_ov,
  output logic                    dp_rst,
  output logic                    dp_start,
  output logic [N_WIDTH-1:0]      dp_n,
  output logic [X_WIDTH-1:0]      dp_x,
  input  logic                    dp_ready,
  input  logic                    dp_valid,
  input  logic [OUTPUT_WIDTH-1:0] dp_y,
  input  logic                    dp_overflow,
  input  logic                    dp_error,
  output logic [2:0]              dbg_state
);

  localparam logic [DW-1:0] DRAIN_LIM = DW'(DRAIN_MAX);

  seq_state_t    state, state_nxt;
  logic [LW-1:0] len, idx, rcv;
  logic [DW-1:0] drain_cnt;
  logic          abort, abort_set, zero_done;
  logic          active, last_issue;

  maclaurin_sample_buf #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (ld_we && !busy),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (idx[AW-1:0]),
    .rdata (dp_x)
  );

  // dp_x is consumed on every FEED cycle with dp_ready=1 (and no dp_error);
  // results are a valid-only strobe forwarded with no backpressure.
  assign active     = (state == START) || (state == CONFIG) ||
                      (state == FEED)  || (state == DRAIN);
  assign last_issue = (idx == len - LW'(1));

  always_comb begin
    state_nxt = state;
    abort_set = 1'b0;
    case (state)
      IDLE:   if (job_start && job_len != '0) state_nxt = START;
      START:  state_nxt = CONFIG;
      CONFIG: state_nxt = FEED;
      FEED:   if (dp_ready && last_issue) state_nxt = DRAIN;
      DRAIN: begin
        if (rcv == len) begin
          state_nxt = FLUSH;
        end else if (drain_cnt == DRAIN_LIM) begin
          state_nxt = FLUSH;
          abort_set = 1'b1;
        end
      end
      FLUSH:  state_nxt = GAP;
      GAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A datapath error overrides any other transition, including final feed.
    if (active && dp_error) begin
      state_nxt = FLUSH;
      abort_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      idx       <= '0;
      rcv       <= '0;
      ov_count  <= '0;
      drain_cnt <= '0;
      abort     <= 1'b0;
      zero_done <= 1'b0;
      dp_n      <= '0;
    end else begin
      state     <= state_nxt;
      zero_done <= (state == IDLE) && job_start && (job_len == '0);
      if (state == IDLE) begin
        if (job_start) begin
          dp_n      <= job_n;
          len       <= job_len;
          idx       <= '0;
          rcv       <= '0;
          ov_count  <= '0;
          drain_cnt <= '0;
        end
      end else begin
        if (state == FEED && dp_ready && !dp_error) idx <= idx + LW'(1);
        if (dp_valid && rcv != len) begin
          rcv <= rcv + LW'(1);
          if (dp_overflow) ov_count <= ov_count + LW'(1);
        end
        if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
      end
      if (state == GAP)   abort <= 1'b0;
      else if (abort_set) abort <= 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == GAP) || zero_done;
  assign done_err  = (state == GAP) && abort;
  assign dp_start  = (state == START);
  assign dp_rst    = rst || (state == FLUSH);
  assign res_valid = dp_valid;
  assign res_y     = dp_y;
  assign res_ov    = dp_overflow;
  assign dbg_state = state;

endmodule

// File: tb/tb_maclaurin_seq_ctrl.sv
// Directed bench for maclaurin_seq_ctrl with a one-cycle-latency datapath model.
module tb_maclaurin_seq_ctrl;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_we;
  logic [4:0]    ld_addr;
  logic [7:0]    ld_data;
  logic          job_start;
  logic [2:0]    job_n;
  logic [5:0]    job_len;
  logic          busy, done, done_err;
  logic [5:0]    ov_count;
  logic          res_valid, res_ov;
  logic [OW-1:0] res_y;
  logic          dp_rst, dp_start;
  logic [2:0]    dp_n;
  logic [7:0]    dp_x;
  logic          dp_ready, dp_valid, dp_overflow, dp_error;
  logic [OW-1:0] dp_y;
  logic [2:0]    dbg_state;

  maclaurin_seq_ctrl #(.OUTPUT_WIDTH(OW), .DEPTH(32), .DRAIN_MAX(16)) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .job_start(job_start), .job_n(job_n), .job_len(job_len),
    .busy(busy), .done(done), .done_err(done_err), .ov_count(ov_count),
    .res_valid(res_valid), .res_y(res_y), .res_ov(res_ov),
    .dp_rst(dp_rst), .dp_start(dp_start), .dp_n(dp_n), .dp_x(dp_x),
    .dp_ready(dp_ready), .dp_valid(dp_valid), .dp_y(dp_y),
    .dp_overflow(dp_overflow), .dp_error(dp_error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  sbuf [32];
  logic [OW:0] exp_q [$];

  // n, len, ready_mode(0 always / 1 toggle), overflow result numbers (1-based),
  // err_at sample index (-1 none), withhold last result, then expectations.
  typedef struct {
    int n; int len; int ready_mode; int ov_a; int ov_b; int err_at; int withhold;
    int exp_err; int exp_ov; int exp_issued; int exp_results; int exp_done_k;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_y(input logic [7:0] x, input int n);
    int xi;
    xi = int'($signed(x));
    return OW'(xi * (n + 1));
  endfunction

  // driver: runs one job, playing the datapath and scoring every output
  task automatic run_job(input vec_t v);
    int k, accepted, results, starts, rsts, feed_k, done_k;
    bit err_fired, feeding, pend_v, pend_ov;
    logic [OW-1:0] pend_y;
    logic [OW:0] e;
    k = 0; accepted = 0; results = 0; starts = 0; rsts = 0;
    feed_k = 1000; done_k = -1; err_fired = 0; pend_v = 0; pend_ov = 0; pend_y = '0;
    exp_q.delete();
    @(posedge clk); #1;
    job_n = 3'(v.n); job_len = 6'(v.len); job_start = 1'b1;
    while (done_k < 0 && k < 100) begin
      @(posedge clk); #1;
      job_start = 1'b0;
      k++;
      dp_valid = pend_v; dp_y = pend_y; dp_overflow = pend_ov; pend_v = 0;
      feeding  = (k >= feed_k) && (accepted < v.len) && !err_fired;
      dp_error = feeding && (accepted == v.err_at);
      dp_ready = feeding && (v.ready_mode == 0 || ((k - feed_k) % 2 == 0));
      #1;
      if (dp_error) err_fired = 1;
      if (k == 1) chk("busy_k1", busy, v.len != 0);
      if (dp_start) begin
        starts++;
        if (starts == 1) begin
          feed_k = k + 2;
          chk("start_cycle", k, 1);
        end
      end
      if (feeding) chk("dp_x", dp_x, sbuf[accepted]);
      if (dp_ready && !dp_error) begin
        pend_ov = (accepted + 1 == v.ov_a) || (accepted + 1 == v.ov_b);
        pend_y  = model_y(dp_x, v.n);
        pend_v  = !(v.withhold != 0 && accepted == v.len - 1);
        if (pend_v) exp_q.push_back({pend_ov, model_y(sbuf[accepted], v.n)});
        accepted++;
      end
      if (res_valid) begin
        results++;
        if (exp_q.size() == 0) chk("res_extra", results, 0);
        else begin
          e = exp_q.pop_front();
          chk("res_y", res_y, e[OW-1:0]);
          chk("res_ov", res_ov, e[OW]);
        end
      end
      if (dp_rst) begin
        rsts++;
        pend_v = 0;
        if (err_fired) chk("x_frozen", dp_x, sbuf[v.err_at]);
      end
      if (done) begin
        done_k = k;
        chk("done_err", done_err, v.exp_err);
        chk("ov_count", ov_count, v.exp_ov);
        chk("dp_n_hold", dp_n, v.n);
      end
    end
    chk("done_cycle", done_k, v.exp_done_k);
    chk("issued", accepted, v.exp_issued);
    chk("results", results, v.exp_results);
    chk("start_pulses", starts, v.len != 0);
    chk("rst_pulses", rsts, v.len != 0);
    chk("exp_q_left", exp_q.size(), 0);
    @(posedge clk); #1;
    dp_valid = 0; dp_ready = 0; dp_error = 0; dp_overflow = 0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    vec_t tail;
    bit saw_done;
    rst = 1; ld_we = 0; ld_addr = '0; ld_data = '0; job_start = 0; job_n = '0; job_len = '0;
    dp_ready = 0; dp_valid = 0; dp_y = '0; dp_overflow = 0; dp_error = 0;
    for (int i = 0; i < 32; i++) sbuf[i] = 8'((i * 53 + 17) % 256);
    vecs[0] = '{2, 20, 0, 0, 0, -1, 0, 0, 0, 20, 20, 26};
    vecs[1] = '{1, 5, 1, 0, 0, -1, 0, 0, 0, 5, 5, 15};
    vecs[2] = '{3, 10, 0, 3, 7, -1, 0, 0, 2, 10, 10, 16};
    vecs[3] = '{0, 10, 0, 0, 0, 4, 0, 1, 0, 4, 4, 9};
    vecs[4] = '{4, 6, 0, 0, 0, -1, 1, 1, 0, 6, 5, 27};
    vecs[5] = '{7, 3, 0, 0, 0, 2, 0, 1, 0, 2, 2, 7};
    vecs[6] = '{5, 1, 0, 0, 0, -1, 0, 0, 0, 1, 1, 7};
    vecs[7] = '{6, 32, 0, 1, 32, -1, 0, 0, 2, 32, 32, 38};
    vecs[8] = '{3, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_ov_count", ov_count, 0);
    chk("rst_dp_n", dp_n, 0);
    chk("rst_dp_rst", dp_rst, 1);
    rst = 0;
    #1;
    chk("run_dp_rst", dp_rst, 0);

    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      ld_we = 1; ld_addr = 5'(i); ld_data = sbuf[i];
    end
    @(posedge clk); #1;
    ld_we = 0;

    for (int i = 0; i < 9; i++) run_job(vecs[i]);

    // reset during DRAIN, with a load and a job_start attempted while busy
    @(posedge clk); #1;
    job_n = 3'd5; job_len = 6'd6; job_start = 1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      job_start = 0; ld_we = 0;
      dp_ready = (k >= 3 && k <= 8);
      if (k == 5) begin
        ld_we = 1; ld_addr = 5'd0; ld_data = ~sbuf[0];
        job_start = 1; job_n = 3'd1; job_len = 6'd1;
      end
      if (k == 12) begin
        #1;
        chk("drain_busy", busy, 1);
        chk("dp_n_kept", dp_n, 5);
      end
      if (k == 13) begin
        rst = 1;
        #1;
        chk("mid_rst_dp_rst", dp_rst, 1);
      end
    end
    @(posedge clk); #1;
    rst = 0; dp_ready = 0;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_ov", ov_count, 0);
    chk("post_rst_dp_rst", dp_rst, 0);
    saw_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    chk("no_done_after_rst", saw_done, 0);

    tail = '{2, 4, 0, 0, 0, -1, 0, 0, 0, 4, 4, 10};
    run_job(tail);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
